tub_scan_driver: RTL and testbench

- Display back-end that produces the `tub_segments1`, `tub_segments2` and `tub_segment_select` signals the top level routes to the 8-digit seven-segment board.
- Takes eight hex digits plus per-digit decimal-point, blank and blink masks, and time-multiplexes them one digit at a time.
- Uses a frame-synchronous shadow load so a digit update never tears mid-frame.
- Replaces ad-hoc per-feature segment encoding in the clock, gesture-time and warning-time displays with one scanner.

---
 rtl/tub_scan_driver_pkg.sv | 34 +++
 rtl/tub_scan_driver_if.sv | 26 ++
 rtl/tub_scan_driver_hex_to_seg.sv | 36 +++
 rtl/tub_scan_driver.sv | 132 +++++++++++++
 tb/tb_tub_scan_driver.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/tub_scan_driver_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment bytes are {a,b,c,d,e,f,g,dp}, active-high.
package tub_pkg;

   localparam int         DIGITS   = 8;
   localparam logic [7:0] SEL_BASE = 8'h80;

   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_0 = 8'hFC;
   localparam logic [7:0] SEG_1 = 8'h60;
   localparam logic [7:0] SEG_2 = 8'hDA;
   localparam logic [7:0] SEG_3 = 8'hF2;
   localparam logic [7:0] SEG_4 = 8'h66;
   localparam logic [7:0] SEG_5 = 8'hB6;
   localparam logic [7:0] SEG_6 = 8'hBE;
   localparam logic [7:0] SEG_7 = 8'hE0;
   localparam logic [7:0] SEG_8 = 8'hFE;
   localparam logic [7:0] SEG_9 = 8'hF6;
   localparam logic [7:0] SEG_A = 8'hEE;
   localparam logic [7:0] SEG_B = 8'h3E;
   localparam logic [7:0] SEG_C = 8'h9C;
   localparam logic [7:0] SEG_D = 8'h7A;
   localparam logic [7:0] SEG_E = 8'h9E;
   localparam logic [7:0] SEG_F = 8'h8E;

   // One complete display image: digits plus the three per-digit masks.
   typedef struct packed {
      logic [31:0] digits;
      logic [7:0]  dp;
      logic [7:0]  blank;
      logic [7:0]  blink;
   } disp_cfg_t;

endpackage

// File: rtl/tub_scan_driver_if.sv
// Producer-to-scanner display bus: image inputs, load strobe and the
// multiplexed board-facing outputs.
interface tub_scan_driver_if;

   logic [31:0] digits;
   logic [7:0]  dp_mask;
   logic [7:0]  blank_mask;
   logic [7:0]  blink_mask;
   logic        load;

   logic [7:0]  tub_segments1;
   logic [7:0]  tub_segments2;
   logic [7:0]  tub_segment_select;
   logic        frame_done;

   modport master (
      output digits, dp_mask, blank_mask, blink_mask, load,
      input  tub_segments1, tub_segments2, tub_segment_select, frame_done
   );

   modport slave (
      input  digits, dp_mask, blank_mask, blink_mask, load,
      output tub_segments1, tub_segments2, tub_segment_select, frame_done
   );

endinterface

// File: rtl/tub_scan_driver_hex_to_seg.sv
// Combinational hex code + decimal point to seven-segment pattern.
// Every code is defined so any display producer can reuse it.
module hex_to_seg
   import tub_pkg::*;
(
   input  logic [3:0] code,
   input  logic       dp,
   output logic [7:0] seg
);

   // Letterforms A,b,C,d,E,F; dp rides in bit 0.
   always_comb begin
      seg = SEG_BLANK;
      case (code)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_BLANK;
      endcase
      seg[0] = dp;
   end

endmodule

// File: rtl/tub_scan_driver.sv
// Eight-digit seven-segment scanner. Digits are shown one at a time at
// DIGIT_HZ; new images are staged in a pending register and only become
// active on the frame boundary so a frame never mixes two images.
module tub_scan_driver
   import tub_pkg::*;
#(
   parameter int CLK_HZ   = 100_000_000,
   parameter int DIGIT_HZ = 1000,
   parameter int BLINK_HZ = 2
) (
   input logic              clk,
   input logic              reset,
   tub_scan_driver_if.slave bus
);

   localparam int DIV       = CLK_HZ / DIGIT_HZ;
   localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
   localparam int DW        = $clog2(DIV + 1);
   localparam int BW        = $clog2(BLINK_DIV + 1);
   localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic [2:0]    idx;
   logic          tick;
   logic          frame_tick;

   logic [BW-1:0] blink_cnt;
   logic          blink_phase;

   disp_cfg_t     cfg_in;
   disp_cfg_t     pending;
   disp_cfg_t     active;
   logic          pend_vld;

   logic [DIGITS-1:0][7:0] lane_pat;
   logic [7:0]    cur_pat;
   logic          hide;

   logic [7:0]    seg1_q;
   logic [7:0]    seg2_q;
   logic [7:0]    sel_q;

   assign tick       = (div_cnt == DIV_LAST);
   assign frame_tick = tick && (idx == 3'd7);

   assign cfg_in = '{digits: bus.digits,
                     dp:     bus.dp_mask,
                     blank:  bus.blank_mask,
                     blink:  bus.blink_mask};

   // Digit-rate divider and scan index; index wraps 7->0 at frame end.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
         idx     <= 3'd0;
      end else if (tick) begin
         div_cnt <= '0;
         idx     <= idx + 3'd1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Free-running blink phase, shared by all blinking digits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + 1'b1;
      end
   end

   // Stage loads; promote to active only on the frame boundary. A load
   // landing on the boundary itself bypasses pending so it is not a frame late.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending  <= '0;
         active   <= '0;
         pend_vld <= 1'b0;
      end else if (frame_tick) begin
         if (bus.load) begin
            active   <= cfg_in;
            pend_vld <= 1'b0;
         end else if (pend_vld) begin
            active   <= pending;
            pend_vld <= 1'b0;
         end
      end else if (bus.load) begin
         pending  <= cfg_in;
         pend_vld <= 1'b1;
      end
   end

   // One decoder per digit position; the scan index just picks a lane.
   for (genvar k = 0; k < DIGITS; k++) begin : g_lane
      hex_to_seg u_dec (
         .code (active.digits[31-4*k -: 4]),
         .dp   (active.dp[DIGITS-1-k]),
         .seg  (lane_pat[k])
      );
   end

   // Mask bit for digit k sits at 7-k, i.e. ~idx.
   always_comb begin
      hide    = active.blank[~idx] | (active.blink[~idx] & blink_phase);
      cur_pat = hide ? SEG_BLANK : lane_pat[idx];
   end

   // Register outputs so the board only ever sees clean edges.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg1_q <= 8'h00;
         seg2_q <= 8'h00;
         sel_q  <= 8'h00;
      end else begin
         seg1_q <= idx[2] ? SEG_BLANK : cur_pat;
         seg2_q <= idx[2] ? cur_pat   : SEG_BLANK;
         sel_q  <= SEL_BASE >> idx;
      end
   end

   assign bus.tub_segments1      = seg1_q;
   assign bus.tub_segments2      = seg2_q;
   assign bus.tub_segment_select = sel_q;
   assign bus.frame_done         = frame_tick;

endmodule

// File: tb/tb_tub_scan_driver.sv
// Bench for tub_scan_driver: directed scenarios plus random loads, every
// cycle compared against a time-based reference of the display.
module tb_tub_scan_driver;

   localparam int DIV   = 10;
   localparam int BDIV  = 100;
   localparam int FRAME = 8 * DIV;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   tub_scan_driver_if bus();

   tub_scan_driver #(.CLK_HZ(1000), .DIGIT_HZ(100), .BLINK_HZ(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Lit segments for each hex glyph.
   string segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                        "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                        "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   int n_chk  = 0;
   int n_fail = 0;

   // Reference state: n = clock edges since reset release.
   int          n;
   logic [31:0] a_dig, p_dig;
   logic [7:0]  a_dp, a_bl, a_bk, p_dp, p_bl, p_bk;
   bit          pv;
   logic [7:0]  e_s1, e_s2, e_sel;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [7:0] seg_of(int v);
      string      s = segs[v];
      logic [7:0] r = 8'h00;
      for (int i = 0; i < s.len(); i++) r[7 - (int'(s[i]) - 97)] = 1'b1;
      return r;
   endfunction

   function automatic int m_idx();
      return (n / DIV) % 8;
   endfunction

   function automatic logic [7:0] m_pat();
      int         k   = m_idx();
      int         b   = 7 - k;
      logic [3:0] nib = 4'((a_dig >> (28 - 4 * k)) & 32'hF);
      if (a_bl[b] || (a_bk[b] && ((n / BDIV) % 2 == 1))) return 8'h00;
      return seg_of(int'(nib)) | {7'b0, a_dp[b]};
   endfunction

   task automatic model_reset();
      n = 0; pv = 0;
      a_dig = '0; a_dp = '0; a_bl = '0; a_bk = '0;
      p_dig = '0; p_dp = '0; p_bl = '0; p_bk = '0;
      e_s1 = '0; e_s2 = '0; e_sel = '0;
   endtask

   task automatic check_outs();
      chk("seg1",   bus.tub_segments1,      e_s1);
      chk("seg2",   bus.tub_segments2,      e_s2);
      chk("select", bus.tub_segment_select, e_sel);
      chk("frame_done", bus.frame_done, (n % DIV == DIV - 1) && (m_idx() == 7));
   endtask

   // Called at a negedge: check, drive the next edge's inputs, advance model.
   task automatic step(input bit ld, input logic [31:0] d,
                       input logic [7:0] dp, input logic [7:0] bl, input logic [7:0] bk);
      int k;
      bit bnd;
      logic [7:0] pt;
      check_outs();
      bus.load = ld; bus.digits = d;
      bus.dp_mask = dp; bus.blank_mask = bl; bus.blink_mask = bk;
      k   = m_idx();
      pt  = m_pat();
      bnd = (n % FRAME) == FRAME - 1;
      e_s1  = (k < 4) ? pt : 8'h00;
      e_s2  = (k < 4) ? 8'h00 : pt;
      e_sel = 8'h80 >> k;
      if (bnd && ld) begin
         a_dig = d; a_dp = dp; a_bl = bl; a_bk = bk; pv = 0;
      end else if (bnd && pv) begin
         a_dig = p_dig; a_dp = p_dp; a_bl = p_bl; a_bk = p_bk; pv = 0;
      end
      if (ld && !bnd) begin
         p_dig = d; p_dp = dp; p_bl = bl; p_bk = bk; pv = 1;
      end
      n++;
      @(negedge clk);
   endtask

   // Idle cycles still drive random data so an ungated load path shows up.
   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++)
         step(0, $urandom, 8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   initial begin
      bus.load = 0; bus.digits = '0;
      bus.dp_mask = '0; bus.blank_mask = '0; bus.blink_mask = '0;
      model_reset();
      repeat (3) begin
         @(negedge clk);
         check_outs();
      end
      reset = 1'b1;

      // Basic image; visible from the first frame boundary.
      step(1, 32'h0123_4567, 8'h00, 8'h00, 8'h00);
      idle(2 * FRAME + 10);

      // Mid-frame load at index 3 must wait for the next frame.
      for (int i = 0; i < FRAME && m_idx() != 3; i++) idle(1);
      step(1, 32'hFFFF_FFFF, 8'h00, 8'h00, 8'h00);
      idle(FRAME + 20);

      // Load exactly on the boundary tick goes straight to active.
      for (int i = 0; i < FRAME && (n % FRAME) != FRAME - 1; i++) idle(1);
      step(1, 32'h89AB_CDEF, 8'h00, 8'h00, 8'h00);
      idle(FRAME);

      // Blank right group, decimal point on digit 0.
      step(1, 32'h0123_4567, 8'h80, 8'h0F, 8'h00);
      idle(2 * FRAME);

      // Blink the two leftmost digits across several phases.
      step(1, 32'hABCD_EF01, 8'h00, 8'h00, 8'hC0);
      idle(4 * BDIV);

      // Random loads at random points, including back-to-back overwrites.
      for (int i = 0; i < 40; i++) begin
         idle($urandom_range(0, 60));
         step(1, $urandom, 8'($urandom), 8'($urandom), 8'($urandom));
      end
      idle(FRAME + 10);

      // Asynchronous reset mid-scan at index 5.
      for (int i = 0; i < FRAME && !(m_idx() == 5 && (n % DIV) == 3); i++) idle(1);
      reset = 1'b0;
      #1;
      model_reset();
      check_outs();
      repeat (3) begin
         @(negedge clk);
         check_outs();
      end
      reset = 1'b1;
      idle(FRAME + 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
